seq_mul_div: RTL and testbench
==============================

Name: seq_mul_div

Overview:
- Parametrised, iterative multiply/divide unit. It is the clocked successor to the combinational 16-bit array multiplier and operator-based divider.
- Performs one shift-add (multiply) or restoring-subtract (divide) step per cycle, so area stays flat as WIDTH grows.
- Adds signed/unsigned mode, remainder output, divide-by-zero detection and a start/busy/done handshake.
- Sits in the ALU datapath beside the single-cycle add/logic ops; the ALU controller stalls on busy.

Parameters:
- WIDTH, 16, operand width in bits (>= 4). Product is 2*WIDTH bits; quotient and remainder are WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only in IDLE or DONE state
- op  input  1  0 = multiply, 1 = divide; sampled at accept
- sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
- A  input  WIDTH  multiplicand / dividend; sampled at accept
- B  input  WIDTH  multiplier / divisor; sampled at accept
- busy  output  1  high while in RUN or FIX
- done  output  1  one-cycle pulse; results valid
- P  output  2*WIDTH  product (multiply only)
- Quotient  output  WIDTH  quotient (divide only)
- Remainder  output  WIDTH  remainder (divide only)
- div_by_zero  output  1  set with done when op=1 and B==0

Behaviour:
- Reset (synchronous, rst_n low at rising edge):
  - State goes to IDLE.
  - busy, done, P, Quotient, Remainder and div_by_zero all clear to 0.
  - Reset overrides everything, including mid-operation. In-flight work is discarded and no done is issued.
- State machine: IDLE -> RUN -> FIX -> DONE -> IDLE.
  - IDLE: on start=1, capture op, sgn, A and B; go to RUN.
  - RUN: exactly WIDTH cycles, counted by a log2(WIDTH)+1-bit counter. One iteration per cycle, on operand magnitudes when sgn=1.
  - FIX: one cycle. Apply sign correction, then load the result registers.
  - DONE: done=1 for this cycle only. On start=1, accept a new operation (go to RUN); otherwise go to IDLE.
- Latency: if start is accepted at edge k, done is high in the cycle following edge k+WIDTH+1. For WIDTH=16 that is a 17-cycle latency. Back-to-back throughput is one operation per WIDTH+2 cycles.
- Handshake:
  - start while busy=1 is ignored; it is not queued.
  - Changes to A, B, op or sgn after accept have no effect.
- Result holding:
  - Result outputs hold their values from the done cycle until the FIX cycle of the next operation.
  - Fields not written by the current op keep their previous values.
  - div_by_zero is rewritten on every done.
- Multiply:
  - Unsigned: P = A*B, full 2*WIDTH bits, no truncation.
  - Signed: P = A*B as a 2*WIDTH-bit two's-complement value. Magnitudes are multiplied, and the result is negated in FIX when sign(A) XOR sign(B).
- Divide:
  - Restoring division on magnitudes.
  - Quotient truncates toward zero; Remainder takes the dividend's sign.
  - Invariant: A == Quotient*B + Remainder, in WIDTH-bit arithmetic.
- Divide by zero (B==0):
  - The operation still takes the full latency.
  - Quotient = all ones, Remainder = A, div_by_zero=1.
  - This applies regardless of sgn.
- Signed overflow, A = -2^(WIDTH-1) with B = -1: Quotient = -2^(WIDTH-1) (0x8000 for WIDTH=16), Remainder = 0, div_by_zero=0.
- Most-negative operand: the 0x8000 magnitude must be handled with a WIDTH+1-bit internal magnitude or an equivalent, with no loss.
- Implementation constraints: no combinational path from inputs to outputs. The "*", "/" and "%" operators are not used in synthesisable RTL.

Test Plan (WIDTH=16):
- Unsigned multiply, A=0xFFFF, B=0xFFFF, sgn=0 -> P=0xFFFE0001, done exactly 17 cycles after accept, busy high for 16+1 cycles.
- Signed multiply, A=0xFFFD (-3), B=0x0005 -> P=0xFFFFFFF1; A=0x8000, B=0x8000 -> P=0x40000000.
- Divide:
  - Unsigned 100/7 -> Quotient=14, Remainder=2.
  - Signed 0xFFF9 (-7) / 2 -> Quotient=0xFFFD, Remainder=0xFFFF.
  - Signed 0x8000 / 0xFFFF -> Quotient=0x8000, Remainder=0, div_by_zero=0.
- Divide by zero, A=0x04D2, B=0 -> Quotient=0xFFFF, Remainder=0x04D2, div_by_zero=1. A following valid divide clears div_by_zero.
- Handshake:
  - start pulsed mid-RUN is ignored; the result is unchanged.
  - start held high during DONE starts the next op immediately, giving a second done 18 cycles after the first.
- rst_n low for one edge at RUN cycle 8 -> all outputs 0 the next cycle, no done pulse. The next start completes normally.

Source files
------------

// File: rtl/seq_mul_div_if.sv
// Handshake and result bundle for the iterative multiply/divide unit.
// The controller drives the request through the master modport; the unit uses the slave modport.
interface seq_mul_div_if #(
  parameter int WIDTH = 16
) ();

  logic                 start;
  logic                 op;
  logic                 sgn;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   P;
  logic [WIDTH-1:0]     Quotient;
  logic [WIDTH-1:0]     Remainder;
  logic                 div_by_zero;

  modport master (
    output start, op, sgn, A, B,
    input  busy, done, P, Quotient, Remainder, div_by_zero
  );

  modport slave (
    input  start, op, sgn, A, B,
    output busy, done, P, Quotient, Remainder, div_by_zero
  );

endinterface

// File: rtl/seq_mul_div.sv
// Iterative multiply/divide: one shift-add or restoring-subtract step per cycle on
// operand magnitudes, sign fix-up in a single FIX cycle, then a one-cycle done pulse.
module seq_mul_div #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mul_div_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_iter;

  // Captured operation and iteration registers
  logic               op_q;
  logic               a_neg, b_neg;
  logic               dz_q;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  // Request decoding at accept time
  logic               a_neg_in, b_neg_in;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;

  // One iteration step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;

  // Sign-corrected results
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  // Result registers
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   quo_q, rem_q;
  logic               dbz_q;

  assign accept    = bus.start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_iter) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    a_neg_in = bus.sgn & bus.A[WIDTH-1];
    b_neg_in = bus.sgn & bus.B[WIDTH-1];
    a_mag_in = a_neg_in ? -bus.A : bus.A;
    b_mag_in = b_neg_in ? -bus.B : bus.B;
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
  end

  // NOTE: the datapath carries no reset; it is always reloaded on accept and only the
  // architectural state and result registers need a defined value after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= bus.op;
      a_neg <= a_neg_in;
      b_neg <= b_neg_in;
      b_mag <= b_mag_in;
      dz_q  <= (bus.B == '0);
      hi    <= '0;
      lo    <= a_mag_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + CNT_W'(1);
      if (!op_q) begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end else if (div_ge) begin
        hi <= WIDTH'(div_shift - {1'b0, b_mag});
        lo <= {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi <= div_shift[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // With a zero divisor every trial subtract succeeds, so hi ends up holding |A|.
  always_comb begin
    prod_mag = {hi, lo};
    prod_res = (a_neg ^ b_neg) ? -prod_mag : prod_mag;
    quo_res  = dz_q ? '1 : ((a_neg ^ b_neg) ? -lo : lo);
    rem_res  = a_neg ? -hi : hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else if (state == FIX) begin
      if (!op_q) begin
        p_q   <= prod_res;
        dbz_q <= 1'b0;
      end else begin
        quo_q <= quo_res;
        rem_q <= rem_res;
        dbz_q <= dz_q;
      end
    end
  end

  assign bus.busy        = (state == RUN) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.P           = p_q;
  assign bus.Quotient    = quo_q;
  assign bus.Remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Scoreboard bench for seq_mul_div: expected results are queued at accept and
// compared, together with latency and busy length, when done pulses.
module tb_seq_mul_div;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] p;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dz;
    int             acc_cyc;
    bit             b2b;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seq_mul_div_if #(.WIDTH(W)) bus ();

  seq_mul_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Reference output state; fields not touched by an op keep their value
  logic [2*W-1:0] m_p  = '0;
  logic [W-1:0]   m_q  = '0;
  logic [W-1:0]   m_r  = '0;
  logic           m_dz = 1'b0;

  int busy_cnt  = 0;
  int last_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sbv, res;
    sa  = s ? longint'($signed(a)) : longint'(a);
    sbv = s ? longint'($signed(b)) : longint'(b);
    if (!o) begin
      res  = sa * sbv;
      m_p  = res[2*W-1:0];
      m_dz = 1'b0;
    end else if (b == '0) begin
      m_q  = '1;
      m_r  = a;
      m_dz = 1'b1;
    end else begin
      res  = sa / sbv;
      m_q  = res[W-1:0];
      res  = sa % sbv;
      m_r  = res[W-1:0];
      m_dz = 1'b0;
    end
  endtask

  task automatic issue(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("issue_wait", 64'(t < 100), 64'(1));
    e.b2b     = bus.done;
    bus.start = 1'b1;
    bus.op    = o;
    bus.sgn   = s;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    model(o, s, a, b);
    e.p       = m_p;
    e.q       = m_q;
    e.r       = m_r;
    e.dz      = m_dz;
    e.acc_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.sgn   = 1'($urandom);
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
  endtask

  task automatic wait_idle(input int gap);
    int t;
    t = 0;
    while ((bus.busy || sb.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", 64'(t < 200), 64'(1));
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_cleared();
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_P", 64'(bus.P), 64'(0));
    check("rst_Quotient", 64'(bus.Quotient), 64'(0));
    check("rst_Remainder", 64'(bus.Remainder), 64'(0));
    check("rst_div_by_zero", 64'(bus.div_by_zero), 64'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.busy) busy_cnt++;
    if (bus.done) begin
      check("done_expected", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("P", 64'(bus.P), 64'(e.p));
        check("Quotient", 64'(bus.Quotient), 64'(e.q));
        check("Remainder", 64'(bus.Remainder), 64'(e.r));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
        check("latency", 64'(cyc - e.acc_cyc), 64'(W + 1));
        check("busy_len", 64'(busy_cnt), 64'(W + 1));
        if (e.b2b) check("b2b_gap", 64'(cyc - last_done), 64'(W + 2));
      end
      busy_cnt  = 0;
      last_done = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.sgn   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared();
    rst_n = 1'b1;

    // Directed multiplies: unsigned full-width, then signed pair back to back
    issue(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    wait_idle(2);
    issue(1'b0, 1'b1, 16'hFFFD, 16'h0005);
    issue(1'b0, 1'b1, 16'h8000, 16'h8000);
    wait_idle(1);

    // Directed divides including overflow and divide-by-zero
    issue(1'b1, 1'b0, 16'd100, 16'd7);
    issue(1'b1, 1'b1, 16'hFFF9, 16'h0002);
    issue(1'b1, 1'b1, 16'h8000, 16'hFFFF);
    wait_idle(3);
    issue(1'b1, 1'b0, 16'h04D2, 16'h0000);
    issue(1'b1, 1'b1, 16'hFB2E, 16'h0000);
    issue(1'b1, 1'b0, 16'd100, 16'd7);
    issue(1'b0, 1'b0, 16'h1234, 16'h0010);
    wait_idle(2);

    // A start pulse in the middle of RUN must be ignored
    issue(1'b1, 1'b1, 16'h1234, 16'hFFF0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.A     = 16'h0003;
    bus.B     = 16'h0003;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(2);

    // Reset in RUN discards the operation and clears every output
    issue(1'b0, 1'b1, 16'h7FFF, 16'h8001);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    busy_cnt = 0;
    m_p  = '0;
    m_q  = '0;
    m_r  = '0;
    m_dz = 1'b0;
    @(negedge clk);
    check_cleared();
    rst_n = 1'b1;
    repeat (W + 6) @(negedge clk);
    issue(1'b1, 1'b1, 16'h8001, 16'h0003);
    wait_idle(1);

    // Random mix, with some zero divisors and varying idle gaps
    for (int i = 0; i < 14; i++) begin
      logic o, s;
      logic [W-1:0] a, b;
      o = 1'($urandom);
      s = 1'($urandom);
      a = W'($urandom);
      b = (i % 4 == 3) ? '0 : W'($urandom);
      issue(o, s, a, b);
      if ($urandom_range(0, 1) == 1) wait_idle($urandom_range(0, 3));
    end
    wait_idle(3);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
